// File: rtl/ex_div_seq.sv
// Multi-cycle radix-2 restoring divider that stalls EX until {remainder, quotient} is ready.
// Define SIGNED_DIV_EN to honour signed_i (DIV); otherwise every divide is unsigned (DIVU).
module ex_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               stallreq_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_busy;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_op1_in;
  logic [WIDTH-1:0]   w_op2_in;

  // r_dvd holds the unconsumed dividend bits and collects quotient bits from the LSB end.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_dvd[WIDTH-2:0], w_qbit};

`ifdef SIGNED_DIV_EN
  logic r_sign1;
  logic r_sign2;
  logic r_signed;

  assign w_op1_in  = (signed_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_op2_in  = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign w_quo_fix = (r_signed & (r_sign1 ^ r_sign2)) ? -w_quo_next : w_quo_next;
  assign w_rem_fix = (r_signed & r_sign1) ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_signed <= 1'b0;
    end else if (r_state == S_FREE && start_i && !annul_i) begin
      r_sign1  <= signed_i & opdata1_i[WIDTH-1];
      r_sign2  <= signed_i & opdata2_i[WIDTH-1];
      r_signed <= signed_i;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_i;
  assign w_op1_in        = opdata1_i;
  assign w_op2_in        = opdata2_i;
  assign w_quo_fix       = w_quo_next;
  assign w_rem_fix       = w_rem_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          if (start_i && !annul_i) begin
            r_busy <= 1'b1;
            if (opdata2_i == '0) begin
              r_state <= S_BYZERO;
            end else begin
              r_state <= S_ON;
              r_cnt   <= '0;
              r_rem   <= '0;
              r_dvd   <= w_op1_in;
              r_dvs   <= w_op2_in;
            end
          end
        end
        S_BYZERO: begin
          r_state  <= S_END;
          r_busy   <= 1'b0;
          r_ready  <= 1'b1;
          r_result <= '0;
        end
        S_ON: begin
          if (annul_i) begin
            r_state <= S_FREE;
            r_busy  <= 1'b0;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= w_quo_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_ITER) begin
              r_state  <= S_END;
              r_busy   <= 1'b0;
              r_ready  <= 1'b1;
              r_result <= {w_rem_fix, w_quo_fix};
            end
          end
        end
        S_END: begin
          if (!start_i || annul_i) begin
            r_state  <= S_FREE;
            r_ready  <= 1'b0;
            r_result <= '0;
          end
        end
        default: r_state <= S_FREE;
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign busy_o     = r_busy;
  assign stallreq_o = start_i & ~r_ready;

endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq: vector table through a result scoreboard, plus
// hand-written annul, reset-abort and start/annul-collision sequences.
module tb_ex_div_seq;

`ifdef SIGNED_DIV_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          annul_i = 1'b0;
  logic          signed_i = 1'b0;
  logic [W-1:0]  opdata1_i = '0;
  logic [W-1:0]  opdata2_i = '0;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          busy_o;
  logic          stallreq_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[14];

  ex_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .result_o(result_o),
    .ready_o(ready_o), .busy_o(busy_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 0) return 64'h0;
    if (sgn && SIGNED_BUILD) begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic run_div(input int idx, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
    int k;
    int exp_lat;
    logic stall_bad;
    logic [63:0] exp_res;
    exp_lat = (b == 0) ? 1 : W;
    stall_bad = 1'b0;
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    sb_q.push_back(vt_exp_lookup(sgn, a, b));
    @(posedge clk); #1;
    chk($sformatf("v%0d_busy", idx), {63'h0, busy_o}, 64'h1);
    k = 0;
    while (!ready_o && k < 100) begin
      if (stallreq_o !== 1'b1) stall_bad = 1'b1;
      if (k == 1) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~sgn;
      end
      @(posedge clk); #1;
      k++;
    end
    if (!ready_o) begin
      chk($sformatf("v%0d_ready_timeout", idx), {63'h0, ready_o}, 64'h1);
      return;
    end
    chk($sformatf("v%0d_latency", idx), 64'(k), 64'(exp_lat));
    chk($sformatf("v%0d_stall_held", idx), {63'h0, stall_bad}, 64'h0);
    chk($sformatf("v%0d_stall_release", idx), {63'h0, stallreq_o}, 64'h0);
    if (sb_q.size() == 0) begin
      chk($sformatf("v%0d_scoreboard_empty", idx), 64'h1, 64'h0);
      exp_res = 64'h0;
    end else begin
      exp_res = sb_q.pop_front();
    end
    chk($sformatf("v%0d_result a=%h b=%h s=%0d", idx, a, b, sgn), result_o, exp_res);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d_hold%0d_ready", idx, h), {63'h0, ready_o}, 64'h1);
      chk($sformatf("v%0d_hold%0d_result", idx, h), result_o, exp_res);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_exit_ready", idx), {63'h0, ready_o}, 64'h0);
    chk($sformatf("v%0d_exit_result", idx), result_o, 64'h0);
  endtask

  // Expected value for a divide comes from the table entry when one matches, else the model.
  function automatic logic [63:0] vt_exp_lookup(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 14; i++)
      if (vt[i].sgn == sgn && vt[i].a == a && vt[i].b == b) return vt[i].exp;
    return model(sgn, a, b);
  endfunction

  initial begin
    logic saw_ready;
    vt[0] = '{1'b0, 32'd100, 32'd7, 64'h00000002_0000000E};
    vt[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,
              SIGNED_BUILD ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000001_7FFFFFFC};
    vt[2] = '{1'b0, 32'd5, 32'd0, 64'h0};
    vt[3] = '{1'b1, 32'd9, 32'd3, 64'h00000000_00000003};
    vt[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
              SIGNED_BUILD ? 64'h00000000_80000000 : 64'h80000000_00000000};
    vt[5] = '{1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF};
    vt[6] = '{1'b1, 32'd7, 32'hFFFFFFFE,
              SIGNED_BUILD ? 64'h00000001_FFFFFFFD : 64'h00000007_00000000};
    vt[7] = '{1'b0, 32'd3, 32'd10, 64'h00000003_00000000};
    for (int i = 8; i < 14; i++) begin
      vt[i].sgn = i[0];
      vt[i].a   = $urandom;
      vt[i].b   = (i < 11) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (vt[i].b == 0) vt[i].b = 32'd1;
      if (vt[i].a == 32'h80000000) vt[i].a = 32'h80000001;
      vt[i].exp = model(vt[i].sgn, vt[i].a, vt[i].b);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'h0, ready_o}, 64'h0);
    chk("reset_busy", {63'h0, busy_o}, 64'h0);
    chk("reset_result", result_o, 64'h0);
    chk("reset_stall", {63'h0, stallreq_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      run_div(i, vt[i].sgn, vt[i].a, vt[i].b, (i == 4) ? 3 : 0);

    // Annul 10 cycles into ON: result is dropped and ready never rises.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    chk("annul_busy", {63'h0, busy_o}, 64'h0);
    chk("annul_ready", {63'h0, ready_o}, 64'h0);
    @(negedge clk);
    annul_i = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) saw_ready = 1'b1;
    end
    chk("annul_no_ready", {63'h0, saw_ready}, 64'h0);
    run_div(20, 1'b1, 32'd9, 32'd3, 0);

    // start and annul in the same cycle: annul wins.
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(posedge clk); #1;
    chk("start_annul_busy", {63'h0, busy_o}, 64'h0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;

    // Reset mid-divide aborts it.
    @(negedge clk);
    start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", {63'h0, ready_o}, 64'h0);
    chk("rst_mid_busy", {63'h0, busy_o}, 64'h0);
    chk("rst_mid_result", result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_free", {63'h0, busy_o}, 64'h0);
    run_div(21, 1'b0, 32'd1000, 32'd3, 1);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
